// File: rtl/pmod_link_if.sv
// pmod_link_if: game-logic side of the Pmod link (transmit request, received frame, link status).
interface pmod_link_if #(
  parameter int unsigned DATA_W = 7
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_changed;
  logic              link_up;

  // Game logic: issues frames, consumes received frames.
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_changed, link_up
  );

  // Link block: accepts frames, presents received frames.
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_changed, link_up
  );
endinterface

// File: rtl/pmod_link.sv
// pmod_link: full-duplex toggle-strobe parallel link between two boards over Pmod pins,
// with input synchronisation, heartbeat resend and link-alive timeout.
module pmod_link #(
  parameter int unsigned DATA_W    = 7,
  parameter int unsigned SETUP     = 4,
  parameter int unsigned HEARTBEAT = 65536,
  parameter int unsigned TIMEOUT   = 262144
) (
  input  logic              clk60MHz,
  input  logic              rst,
  pmod_link_if.slave        link,
  output logic [DATA_W-1:0] pin_out_data,
  output logic              pin_out_strobe,
  input  logic [DATA_W-1:0] pin_in_data,
  input  logic              pin_in_strobe
);

  localparam int unsigned SET_W = (SETUP > 1) ? $clog2(SETUP) : 1;
  localparam int unsigned HB_W  = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2
  } state_t;

  // ---------------------------------------------------------------- transmit
  state_t            state;
  state_t            state_nxt;
  logic [SET_W-1:0]  set_cnt;
  logic [SET_W-1:0]  set_cnt_nxt;
  logic [HB_W-1:0]   hb_cnt;
  logic [HB_W-1:0]   hb_cnt_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              out_strobe_nxt;
  logic              tx_ready_nxt;
  logic              start_c;
  logic              setup_done_c;

  // A frame starts on a user request or when the idle heartbeat interval expires.
  assign start_c      = (state == IDLE) && (link.tx_valid || (hb_cnt == HB_LAST));
  assign setup_done_c = (set_cnt == SET_LAST);

  // TX state register.
  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // TX next-state: IDLE -> PRE (data setup) -> POST (data hold) -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_c)      state_nxt = PRE;
      PRE:     if (setup_done_c) state_nxt = POST;
      POST:    if (setup_done_c) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // TX outputs: next values of the pin/handshake registers and counters.
  always_comb begin
    set_cnt_nxt    = '0;
    hb_cnt_nxt     = '0;
    out_data_nxt   = pin_out_data;
    out_strobe_nxt = pin_out_strobe;
    tx_ready_nxt   = (state_nxt == IDLE);
    case (state)
      IDLE: begin
        // User data wins over a coincident heartbeat; a heartbeat keeps the old data.
        if (link.tx_valid) out_data_nxt = link.tx_data;
        if (!start_c)      hb_cnt_nxt   = hb_cnt + HB_W'(1);
      end
      PRE: begin
        if (setup_done_c) out_strobe_nxt = ~pin_out_strobe;
        else              set_cnt_nxt    = set_cnt + SET_W'(1);
      end
      POST: begin
        if (!setup_done_c) set_cnt_nxt = set_cnt + SET_W'(1);
      end
      default: ;
    endcase
  end

  // TX datapath registers.
  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      set_cnt        <= '0;
      hb_cnt         <= '0;
      pin_out_data   <= '0;
      pin_out_strobe <= 1'b0;
      link.tx_ready  <= 1'b1;
    end else begin
      set_cnt        <= set_cnt_nxt;
      hb_cnt         <= hb_cnt_nxt;
      pin_out_data   <= out_data_nxt;
      pin_out_strobe <= out_strobe_nxt;
      link.tx_ready  <= tx_ready_nxt;
    end
  end

  // ---------------------------------------------------------------- receive
  logic [DATA_W-1:0] din_meta;
  logic [DATA_W-1:0] din_sync;
  logic              strb_meta;
  logic              strb_sync;
  logic              strb_prev;
  logic              frame_c;

  // Either strobe polarity change marks a new frame.
  assign frame_c = strb_sync ^ strb_prev;

  // Two-flop synchronisers on the asynchronous pins, plus previous-strobe flop.
  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      din_meta  <= '0;
      din_sync  <= '0;
      strb_meta <= 1'b0;
      strb_sync <= 1'b0;
      strb_prev <= 1'b0;
    end else begin
      din_meta  <= pin_in_data;
      din_sync  <= din_meta;
      strb_meta <= pin_in_strobe;
      strb_sync <= strb_meta;
      strb_prev <= strb_sync;
    end
  end

  // Capture the frame; data is already settled because the peer holds it around the strobe.
  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      link.rx_data    <= '0;
      link.rx_valid   <= 1'b0;
      link.rx_changed <= 1'b0;
    end else begin
      link.rx_valid   <= frame_c;
      link.rx_changed <= frame_c && (din_sync != link.rx_data);
      if (frame_c) link.rx_data <= din_sync;
    end
  end

  // ---------------------------------------------------------------- link monitor
  logic [TO_W-1:0] to_cnt;

  // Link is alive while strobe edges keep arriving within TIMEOUT cycles.
  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      to_cnt       <= '0;
      link.link_up <= 1'b0;
    end else if (frame_c) begin
      to_cnt       <= '0;
      link.link_up <= 1'b1;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_LAST) link.link_up <= 1'b0;
    end
  end

endmodule

// File: doc/pmod_link.md
# pmod_link

Full-duplex parallel inter-board link between two game FPGAs over the Pmod headers. It generalises the fixed ready/power/throw wiring to a parametrised DATA_W-bit frame with a toggle-strobe transfer. It adds input synchronisation, a periodic heartbeat resend and a link-alive timeout. It sits between the game logic in `top` and the JA (out) / JB (in) pins, and replaces direct pin-to-register wiring.

## Interface
Parameters:
- DATA_W, 7: frame payload width (player ready flags, power, throw flag).
- SETUP, 4: cycles that data is held stable before and after each strobe toggle. Must be ≥ 2.
- HEARTBEAT, 65536: idle cycles before the last frame is resent automatically. Must be ≥ 1.
- TIMEOUT, 262144: cycles without a received strobe edge before `link_up` drops. Must be > HEARTBEAT + 2*SETUP + 4.

Ports:
- clk60MHz, in, 1: single system clock. All logic is on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- tx_data, in, DATA_W: frame to send.
- tx_valid, in, 1: send request. Held until accepted.
- tx_ready, out, 1: transmitter idle. The frame is accepted on an edge where tx_valid && tx_ready.
- rx_data, out, DATA_W: last received frame. Registered.
- rx_valid, out, 1: one-cycle pulse per received frame, including heartbeat frames.
- rx_changed, out, 1: one-cycle pulse, coincident with rx_valid, only when the new rx_data differs from the previous one.
- link_up, out, 1: the peer is alive.
- pin_out_data, out, DATA_W: to JA data pins. Registered.
- pin_out_strobe, out, 1: to a JA pin. Toggle strobe, registered.
- pin_in_data, in, DATA_W: from JB data pins. Asynchronous.
- pin_in_strobe, in, 1: from a JB pin. Asynchronous.

## Operation
Reset values (asynchronous):
- tx_ready = 1.
- rx_data = 0, rx_valid = 0, rx_changed = 0.
- link_up = 0.
- pin_out_data = 0, pin_out_strobe = 0.
- All counters and synchroniser flops = 0.
- TX FSM = IDLE.

TX FSM (IDLE → PRE → POST → IDLE):
- IDLE: tx_ready = 1. The heartbeat counter increments each cycle.
- User frame in IDLE: on acceptance, pin_out_data ← tx_data, the counter clears, and the FSM goes to PRE.
- Heartbeat frame in IDLE: when the heartbeat counter reaches HEARTBEAT-1 and tx_valid = 0, the FSM goes to PRE. pin_out_data is unchanged, so the last frame is resent.
- Simultaneous user request and heartbeat: the user frame wins and the heartbeat counter clears.
- PRE: counts SETUP cycles, then toggles pin_out_strobe and goes to POST.
- POST: counts SETUP cycles, then goes to IDLE. The heartbeat counter clears on entry to IDLE.
- tx_ready = 0 in PRE and POST. tx_data is ignored there.

RX path:
- pin_in_data and pin_in_strobe each pass through a 2-FF synchroniser.
- A third flop holds the previous synchronised strobe.
- Any strobe edge (0→1 or 1→0) counts as a frame.
- On a frame:
  - rx_data ← synchronised data.
  - rx_valid = 1.
  - rx_changed = (synced data != rx_data).
- rx_data is held between frames.
- Because SETUP ≥ 2, the synchronised data is stable before the synchronised strobe edge.

Link monitor:
- The timeout counter clears on every detected strobe edge. Otherwise it increments, saturating at TIMEOUT.
- link_up sets on the first detected edge.
- link_up clears when the counter reaches TIMEOUT, and sets again on the next edge.

## Timing
- Acceptance at edge k:
  - pin_out_data is valid after edge k.
  - pin_out_strobe toggles after edge k+SETUP.
  - tx_ready returns high after edge k+2*SETUP.
  - The earliest next acceptance is edge k+2*SETUP+1.
- Continuous tx_valid gives one frame per 2*SETUP+1 cycles.
- Heartbeat period:
  - With no user traffic, a frame starts every HEARTBEAT cycles of IDLE.
  - Strobe-to-strobe spacing is HEARTBEAT + 2*SETUP cycles.
- RX latency:
  - Let j be the first edge on which the pin_in_strobe change is sampled.
  - rx_valid and rx_data are updated after edge j+2.
  - rx_valid is high for exactly one cycle.
- Loopback (out pins wired to in pins): strobe toggle at edge k+SETUP leads to rx_valid after edge k+SETUP+3.
- Reset mid-frame:
  - All outputs return to reset values immediately (asynchronously).
  - A strobe toggle in progress is aborted.
  - The peer sees either no edge or an edge back to 0.
  - The peer treats an edge back to 0 as a frame carrying data 0.

## Test plan
- Reset: assert rst mid-POST → on the same cycle, tx_ready = 1, pin_out_strobe = 0, pin_out_data = 0, link_up = 0, rx_valid = 0.
- Loopback, SETUP=4, one frame tx_data=7'h55 → one rx_valid pulse 7 cycles after acceptance, rx_data=7'h55, rx_changed=1, link_up=1.
- Back-to-back: tx_valid held with data 7'h01 then 7'h02 → acceptances 9 cycles apart; two rx_valid pulses with rx_data 01 then 02.
- Heartbeat, HEARTBEAT=32: one frame 7'h3C, then idle → strobe toggles every 40 cycles; rx_valid each time with rx_data=3C and rx_changed=0; link_up stays 1.
- Timeout, TIMEOUT=100, loopback strobe cut after first frame → link_up falls exactly 100 cycles after the last edge; reconnecting sets it on the next edge.
- Collision: tx_valid=1 (data 7'h7F) on the heartbeat-expiry cycle → exactly one frame sent, carrying 7'h7F; the heartbeat counter restarts from 0.
